// File: rtl/sram_bus_pkg.sv
// Shared state encodings and arbitration-mode constants for the SRAM bus arbiter.
package sram_bus_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_REQ  = 1'b1
  } w_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: fixed priority from index 0, or round robin searching from ptr_i.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             rr_mode_i,
  output logic [N-1:0]     gnt_o
);

  logic [PTR_W-1:0] base_ptr;
  logic [2*N-1:0]   req_dbl;
  logic [2*N-1:0]   gnt_dbl;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     gnt_rot;

  // Rotate so the search start sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    base_ptr = rr_mode_i ? ptr_i : '0;
    req_dbl  = {req_i, req_i} >> base_ptr;
    req_rot  = req_dbl[N-1:0];
    gnt_rot  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_rot    = '0;
        gnt_rot[k] = 1'b1;
      end
    end
    gnt_dbl = {{N{1'b0}}, gnt_rot} << base_ptr;
    gnt_o   = gnt_dbl[2*N-1:N] | gnt_dbl[N-1:0];
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// N-master to one-SRAM-port arbiter with independent read and write channels,
// one outstanding transaction each, and read-after-write line blocking.
module sram_bus_arbiter
  import sram_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int TYPE_W      = 6,
  parameter int STRB_W      = 16,
  parameter int ARB_MODE    = 1,
  parameter int LINE_OFF    = 5,
  parameter int RAW_BLOCK   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_r_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_r_addr,
  input  logic [NUM_MASTERS*TYPE_W-1:0] m_r_type,
  output logic [NUM_MASTERS-1:0]        m_r_rdy,
  output logic [DATA_W-1:0]             m_re_data,
  output logic [NUM_MASTERS-1:0]        m_re_valid,
  input  logic [NUM_MASTERS-1:0]        m_w_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_w_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_w_data,
  input  logic [NUM_MASTERS*TYPE_W-1:0] m_w_type,
  input  logic [NUM_MASTERS*STRB_W-1:0] m_w_strb,
  output logic [NUM_MASTERS-1:0]        m_w_rdy,
  output logic                          s_r_req,
  output logic [ADDR_W-1:0]             s_r_addr,
  output logic [TYPE_W-1:0]             s_r_type,
  input  logic                          s_r_rdy,
  input  logic [DATA_W-1:0]             s_re_data,
  input  logic                          s_re_valid,
  output logic                          s_w_req,
  output logic [ADDR_W-1:0]             s_w_addr,
  output logic [DATA_W-1:0]             s_w_data,
  output logic [TYPE_W-1:0]             s_w_type,
  output logic [STRB_W-1:0]             s_w_strb,
  input  logic                          s_w_rdy
);

  localparam int   N       = NUM_MASTERS;
  localparam int   PTR_W   = $clog2(N);
  localparam logic RR_MODE = (ARB_MODE == ARB_RR);

  r_state_e          r_state_q, r_state_d;
  w_state_e          w_state_q, w_state_d;
  logic [N-1:0]      r_gnt_q, r_gnt_d, w_gnt_q, w_gnt_d;
  logic [PTR_W-1:0]  r_ptr_q, r_ptr_d, w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] r_addr_q, w_addr_q;
  logic [TYPE_W-1:0] r_type_q, w_type_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic [N-1:0]      r_elig, r_cand, w_cand;
  logic              r_start, w_start;
  logic [ADDR_W-1:0] r_sel_addr, w_sel_addr;
  logic [TYPE_W-1:0] r_sel_type, w_sel_type;
  logic [DATA_W-1:0] w_sel_data;
  logic [STRB_W-1:0] w_sel_strb;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [N-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_arbiter #(.N(N), .PTR_W(PTR_W)) u_w_arb (
    .req_i     (m_w_req),
    .ptr_i     (w_ptr_q),
    .rr_mode_i (RR_MODE),
    .gnt_o     (w_cand)
  );

  rr_arbiter #(.N(N), .PTR_W(PTR_W)) u_r_arb (
    .req_i     (r_elig),
    .ptr_i     (r_ptr_q),
    .rr_mode_i (RR_MODE),
    .gnt_o     (r_cand)
  );

  assign w_start = (w_state_q == W_IDLE) && (|m_w_req);
  assign r_start = (r_state_q == R_IDLE) && (|r_elig);

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_type = '0;
    w_sel_strb = '0;
    r_sel_addr = '0;
    r_sel_type = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) begin
        w_sel_addr = m_w_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = m_w_data[i*DATA_W +: DATA_W];
        w_sel_type = m_w_type[i*TYPE_W +: TYPE_W];
        w_sel_strb = m_w_strb[i*STRB_W +: STRB_W];
      end
      if (r_cand[i]) begin
        r_sel_addr = m_r_addr[i*ADDR_W +: ADDR_W];
        r_sel_type = m_r_type[i*TYPE_W +: TYPE_W];
      end
    end
  end

  // A read to the in-flight (or just-starting) write line waits; it is released
  // in the cycle the write completes so its grant lands on that same edge.
  always_comb begin
    r_elig = m_r_req;
    for (int i = 0; i < N; i++) begin
      if (RAW_BLOCK != 0) begin
        if ((w_state_q == W_REQ) && !s_w_rdy &&
            (m_r_addr[i*ADDR_W+LINE_OFF +: ADDR_W-LINE_OFF] == w_addr_q[ADDR_W-1:LINE_OFF]))
          r_elig[i] = 1'b0;
        if (w_start &&
            (m_r_addr[i*ADDR_W+LINE_OFF +: ADDR_W-LINE_OFF] == w_sel_addr[ADDR_W-1:LINE_OFF]))
          r_elig[i] = 1'b0;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_gnt_d   = r_gnt_q;
    r_ptr_d   = r_ptr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (r_start) begin
          r_gnt_d   = r_cand;
          r_state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (s_r_rdy) r_state_d = R_RESP;
      end
      R_RESP: begin
        if (s_re_valid) begin
          r_state_d = R_IDLE;
          r_gnt_d   = '0;
          if (RR_MODE) r_ptr_d = next_ptr(r_gnt_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_gnt_d   = w_gnt_q;
    w_ptr_d   = w_ptr_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (w_start) begin
          w_gnt_d   = w_cand;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        if (s_w_rdy) begin
          w_state_d = W_IDLE;
          w_gnt_d   = '0;
          if (RR_MODE) w_ptr_d = next_ptr(w_gnt_q);
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      r_gnt_q   <= '0;
      w_gnt_q   <= '0;
      r_ptr_q   <= '0;
      w_ptr_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_gnt_q   <= r_gnt_d;
      w_gnt_q   <= w_gnt_d;
      r_ptr_q   <= r_ptr_d;
      w_ptr_q   <= w_ptr_d;
    end
  end

  // Request payload is captured at grant and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (r_start) begin
      r_addr_q <= r_sel_addr;
      r_type_q <= r_sel_type;
    end
    if (w_start) begin
      w_addr_q <= w_sel_addr;
      w_data_q <= w_sel_data;
      w_type_q <= w_sel_type;
      w_strb_q <= w_sel_strb;
    end
  end

  assign s_r_req  = !rst && (r_state_q == R_REQ);
  assign s_r_addr = r_addr_q;
  assign s_r_type = r_type_q;
  assign s_w_req  = !rst && (w_state_q == W_REQ);
  assign s_w_addr = w_addr_q;
  assign s_w_data = w_data_q;
  assign s_w_type = w_type_q;
  assign s_w_strb = w_strb_q;

  assign m_r_rdy    = (!rst && (r_state_q == R_REQ)  && s_r_rdy)    ? r_gnt_q : '0;
  assign m_re_valid = (!rst && (r_state_q == R_RESP) && s_re_valid) ? r_gnt_q : '0;
  assign m_w_rdy    = (!rst && (w_state_q == W_REQ)  && s_w_rdy)    ? w_gnt_q : '0;
  assign m_re_data  = s_re_data;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a round-robin instance and a fixed-priority instance.
module tb_sram_bus_arbiter;
  import sram_bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TW = 6;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    m_r_req, f_r_req, m_w_req, f_w_req;
  logic [N*AW-1:0] m_r_addr, m_w_addr;
  logic [N*TW-1:0] m_r_type, m_w_type;
  logic [N*DW-1:0] m_w_data;
  logic [N*SW-1:0] m_w_strb;
  logic            s_r_rdy, s_re_valid, s_w_rdy;
  logic [DW-1:0]   s_re_data;

  logic [N-1:0]  m_r_rdy, m_re_valid, m_w_rdy;
  logic [DW-1:0] m_re_data;
  logic          s_r_req, s_w_req;
  logic [AW-1:0] s_r_addr, s_w_addr;
  logic [TW-1:0] s_r_type, s_w_type;
  logic [DW-1:0] s_w_data;
  logic [SW-1:0] s_w_strb;

  logic [N-1:0]  f_m_r_rdy, f_m_re_valid, f_m_w_rdy;
  logic [DW-1:0] f_m_re_data;
  logic          f_s_r_req, f_s_w_req;
  logic [AW-1:0] f_s_r_addr, f_s_w_addr;
  logic [TW-1:0] f_s_r_type, f_s_w_type;
  logic [DW-1:0] f_s_w_data;
  logic [SW-1:0] f_s_w_strb;

  sram_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW), .STRB_W(SW),
                     .ARB_MODE(1), .LINE_OFF(5), .RAW_BLOCK(1)) dut (
    .clk(clk), .rst(rst),
    .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(m_r_rdy),
    .m_re_data(m_re_data), .m_re_valid(m_re_valid),
    .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
    .m_w_strb(m_w_strb), .m_w_rdy(m_w_rdy),
    .s_r_req(s_r_req), .s_r_addr(s_r_addr), .s_r_type(s_r_type), .s_r_rdy(s_r_rdy),
    .s_re_data(s_re_data), .s_re_valid(s_re_valid),
    .s_w_req(s_w_req), .s_w_addr(s_w_addr), .s_w_data(s_w_data), .s_w_type(s_w_type),
    .s_w_strb(s_w_strb), .s_w_rdy(s_w_rdy)
  );

  sram_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW), .STRB_W(SW),
                     .ARB_MODE(0), .LINE_OFF(5), .RAW_BLOCK(1)) dut_fix (
    .clk(clk), .rst(rst),
    .m_r_req(f_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(f_m_r_rdy),
    .m_re_data(f_m_re_data), .m_re_valid(f_m_re_valid),
    .m_w_req(f_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
    .m_w_strb(m_w_strb), .m_w_rdy(f_m_w_rdy),
    .s_r_req(f_s_r_req), .s_r_addr(f_s_r_addr), .s_r_type(f_s_r_type), .s_r_rdy(s_r_rdy),
    .s_re_data(s_re_data), .s_re_valid(s_re_valid),
    .s_w_req(f_s_w_req), .s_w_addr(f_s_w_addr), .s_w_data(f_s_w_data), .s_w_type(f_s_w_type),
    .s_w_strb(f_s_w_strb), .s_w_rdy(s_w_rdy)
  );

  // Read-channel view of whichever instance is under test.
  logic          use_f;
  logic          obs_s_r_req;
  logic [AW-1:0] obs_s_r_addr;
  logic [N-1:0]  obs_m_r_rdy, obs_m_re_valid;
  assign obs_s_r_req    = use_f ? f_s_r_req    : s_r_req;
  assign obs_s_r_addr   = use_f ? f_s_r_addr   : s_r_addr;
  assign obs_m_r_rdy    = use_f ? f_m_r_rdy    : m_r_rdy;
  assign obs_m_re_valid = use_f ? f_m_re_valid : m_re_valid;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait (bounded) for the downstream read request, then accept and answer it.
  task automatic rd_txn(input string tag, input logic [N-1:0] exp_gnt, input logic [AW-1:0] exp_addr);
    int n;
    n = 0;
    while (obs_s_r_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    @(negedge clk);
    chk({tag, "_sreq"}, obs_s_r_req, 1);
    chk({tag, "_addr"}, obs_s_r_addr, exp_addr);
    s_r_rdy = 1'b1;
    #1;
    chk({tag, "_rrdy"}, obs_m_r_rdy, exp_gnt);
    tick();
    s_r_rdy    = 1'b0;
    s_re_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_rvld"}, obs_m_re_valid, exp_gnt);
    tick();
    s_re_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; use_f = 1'b0;
    m_r_req = '0; f_r_req = '0; m_w_req = '0; f_w_req = '0;
    m_r_addr = '0; m_w_addr = '0; m_r_type = '0; m_w_type = '0; m_w_data = '0; m_w_strb = '0;
    s_r_rdy = 1'b0; s_re_valid = 1'b0; s_w_rdy = 1'b0; s_re_data = '0;

    // Reset state, including downstream strobes arriving during reset.
    tick(); tick();
    @(negedge clk);
    chk("rst_sreq", s_r_req, 0);
    chk("rst_wreq", s_w_req, 0);
    s_r_rdy = 1'b1; s_re_valid = 1'b1; s_w_rdy = 1'b1;
    #1;
    chk("rst_rrdy", m_r_rdy, 0);
    chk("rst_rvld", m_re_valid, 0);
    chk("rst_wrdy", m_w_rdy, 0);
    tick();
    s_r_rdy = 1'b0; s_re_valid = 1'b0; s_w_rdy = 1'b0;
    rst = 1'b0;

    // Single read, cycle by cycle; the requester drops its request after grant.
    tick();
    m_r_req = 4'b0001; m_r_addr[31:0] = 32'h8000_0040;
    @(negedge clk); chk("c1_sreq", s_r_req, 0);
    tick(); m_r_req = '0;
    @(negedge clk); chk("c2_sreq", s_r_req, 1); chk("c2_addr", s_r_addr, 32'h8000_0040);
    chk("c2_rrdy", m_r_rdy, 0);
    tick(); s_r_rdy = 1'b1;
    @(negedge clk); chk("c3_sreq", s_r_req, 1); chk("c3_rrdy", m_r_rdy, 4'b0001);
    tick(); s_r_rdy = 1'b0;
    @(negedge clk); chk("c4_sreq", s_r_req, 0);
    tick(); s_r_rdy = 1'b1;
    @(negedge clk); chk("c5_stray_rrdy", m_r_rdy, 0);
    tick(); s_r_rdy = 1'b0; s_re_valid = 1'b1; s_re_data = {4{64'hDEAD_BEEF_0123_4567}};
    @(negedge clk); chk("c6_rvld", m_re_valid, 4'b0001);
    chk("c6_rdata_lo", m_re_data[63:0], 64'hDEAD_BEEF_0123_4567);
    chk("c6_rdata_hi", m_re_data[255:192], 64'hDEAD_BEEF_0123_4567);
    tick(); s_r_rdy = 1'b1;
    @(negedge clk); chk("c7_idle_rvld", m_re_valid, 0); chk("c7_idle_rrdy", m_r_rdy, 0);
    tick(); s_r_rdy = 1'b0; s_re_valid = 1'b0;

    // Round robin with all four requesting: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) m_r_addr[i*AW +: AW] = 32'h8000_0000 + 32'(i) * 32'h100;
    m_r_req = 4'b1111;
    for (int k = 0; k < 5; k++)
      rd_txn($sformatf("rr%0d", k), 4'(1 << (k % 4)), 32'h8000_0000 + 32'(k % 4) * 32'h100);
    m_r_req = '0;

    // Fixed priority: master 1 always beats master 3.
    do_reset();
    use_f = 1'b1;
    f_r_req = 4'b1010;
    for (int k = 0; k < 3; k++) rd_txn($sformatf("fix%0d", k), 4'b0010, 32'h8000_0100);
    f_r_req = '0;
    tick();
    use_f = 1'b0;

    // Same-line write and read start together: write first, read held until s_w_rdy.
    do_reset();
    m_w_addr[31:0] = 32'h8000_1000; m_w_data[255:0] = {4{64'h1111_2222_3333_4444}};
    m_w_type[5:0] = 6'h2A; m_w_strb[15:0] = 16'hF0F0;
    m_r_addr[63:32] = 32'h8000_101C;
    m_w_req = 4'b0001; m_r_req = 4'b0010;
    @(negedge clk); chk("raw_c0_wreq", s_w_req, 0);
    tick(); m_w_req = '0;
    @(negedge clk);
    chk("raw_wreq", s_w_req, 1); chk("raw_rreq", s_r_req, 0);
    chk("raw_waddr", s_w_addr, 32'h8000_1000); chk("raw_wdata", s_w_data[63:0], 64'h1111_2222_3333_4444);
    chk("raw_wtype", s_w_type, 6'h2A); chk("raw_wstrb", s_w_strb, 16'hF0F0);
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk); chk($sformatf("raw_hold%0d", k), s_r_req, 0);
    end
    tick(); s_w_rdy = 1'b1;
    @(negedge clk); chk("raw_wrdy", m_w_rdy, 4'b0001); chk("raw_hold_wrdy", s_r_req, 0);
    tick(); s_w_rdy = 1'b0;
    @(negedge clk); chk("raw_rel_sreq", s_r_req, 1); chk("raw_rel_wreq", s_w_req, 0);
    m_r_req = '0;
    rd_txn("raw_rd", 4'b0010, 32'h8000_101C);

    // Different line while the write is in flight: granted immediately.
    m_r_addr[95:64] = 32'h8000_2000;
    m_w_req = 4'b0001;
    tick(); m_w_req = '0; m_r_req = 4'b0100;
    @(negedge clk); chk("nraw_c0_sreq", s_r_req, 0);
    tick(); m_r_req = '0;
    @(negedge clk); chk("nraw_sreq", s_r_req, 1); chk("nraw_wreq", s_w_req, 1);
    rd_txn("nraw_rd", 4'b0100, 32'h8000_2000);
    s_w_rdy = 1'b1;
    @(negedge clk); chk("nraw_wrdy", m_w_rdy, 4'b0001);
    tick(); s_w_rdy = 1'b0;

    // Reset while waiting for read data: the late response is dropped.
    m_r_addr[127:96] = 32'h8000_0300;
    m_r_req = 4'b1000;
    tick(); m_r_req = '0;
    @(negedge clk); chk("rstr_sreq", s_r_req, 1);
    tick(); s_r_rdy = 1'b1;
    @(negedge clk); chk("rstr_rrdy", m_r_rdy, 4'b1000);
    tick(); s_r_rdy = 1'b0; rst = 1'b1; s_re_valid = 1'b1;
    @(negedge clk); chk("rstr_rvld_in_rst", m_re_valid, 0);
    tick(); rst = 1'b0;
    @(negedge clk); chk("rstr_rvld_after", m_re_valid, 0); chk("rstr_state", dut.r_state_q, R_IDLE);
    tick(); s_re_valid = 1'b0;
    m_r_req = 4'b1000;
    tick(); m_r_req = '0;
    rd_txn("rstr_again", 4'b1000, 32'h8000_0300);

    // Concurrent read (master 2) and write (master 1) to different lines.
    do_reset();
    m_r_addr[95:64] = 32'h8000_0200; m_r_type[17:12] = 6'h07;
    m_w_addr[63:32] = 32'h8000_3000; m_w_data[511:256] = {4{64'hA5A5_5A5A_0F0F_F0F0}};
    m_w_strb[31:16] = 16'h00FF; m_w_type[11:6] = 6'h15;
    m_r_req = 4'b0100; m_w_req = 4'b0010;
    tick(); m_r_req = '0; m_w_req = '0;
    @(negedge clk);
    chk("cc_sreq", s_r_req, 1); chk("cc_wreq", s_w_req, 1);
    chk("cc_raddr", s_r_addr, 32'h8000_0200); chk("cc_rtype", s_r_type, 6'h07);
    chk("cc_waddr", s_w_addr, 32'h8000_3000); chk("cc_wdata", s_w_data[255:192], 64'hA5A5_5A5A_0F0F_F0F0);
    chk("cc_wstrb", s_w_strb, 16'h00FF); chk("cc_wtype", s_w_type, 6'h15);
    tick(); s_r_rdy = 1'b1; s_w_rdy = 1'b1;
    @(negedge clk); chk("cc_rrdy", m_r_rdy, 4'b0100); chk("cc_wrdy", m_w_rdy, 4'b0010);
    tick(); s_r_rdy = 1'b0; s_w_rdy = 1'b0; s_re_valid = 1'b1;
    @(negedge clk); chk("cc_rvld", m_re_valid, 4'b0100); chk("cc_wreq_done", s_w_req, 0);
    chk("cc_wrdy_done", m_w_rdy, 0);
    tick(); s_re_valid = 1'b0;
    @(negedge clk); chk("cc_sreq_done", s_r_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
